// File: rtl/qeciphy_tx_link_arbiter.sv
// Round-robin arbiter sharing the QECIPHY TX stream, plus the PHY reset / link-up / retrain sequencer.
// Define QECIPHY_ARB_STATS_EN to add per-requester beat counters on stat_beats.
module qeciphy_tx_link_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 64,
  parameter int RST_CYCLES   = 16,
  parameter int LINK_TIMEOUT = 65536,
  parameter int RETRY_WAIT   = 1024
) (
  input  logic                      ACLK,
  input  logic                      rst_n,
  input  logic [NUM_REQ*DATA_W-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]        req_tvalid,
  output logic [NUM_REQ-1:0]        req_tready,
  output logic [DATA_W-1:0]         phy_tdata,
  output logic                      phy_tvalid,
  input  logic                      phy_tready,
  input  logic [3:0]                phy_status,
  input  logic [3:0]                phy_ecode,
  output logic                      phy_arstn,
  output logic                      link_up,
  output logic [7:0]                retrain_cnt
`ifdef QECIPHY_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     stat_beats
`endif
);

  // state      | meaning
  // PHY_RST    | phy_arstn held low for RST_CYCLES
  // WAIT_LINK  | PHY released, waiting for link-up or timeout
  // ACTIVE     | link up, traffic flows
  // ERR_HOLD   | link lost, quiet for RETRY_WAIT before re-reset
  localparam logic [1:0] ST_PHY_RST   = 2'd0;
  localparam logic [1:0] ST_WAIT_LINK = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;
  localparam logic [1:0] ST_ERR_HOLD  = 2'd3;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] TC_RST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TC_LINK  = 32'(LINK_TIMEOUT - 1);
  localparam logic [31:0] TC_RETRY = 32'(RETRY_WAIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [1:0]       state;
  logic [31:0]      timer;
  logic [31:0]      elapsed;
  logic             link_ok;
  logic             handshake;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_sel;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock;

  // Timer counts down from 0 on state entry, so the reset value needs no preload.
  assign elapsed   = 32'd0 - timer;
  assign link_ok   = (phy_status == 4'b0100) && (phy_ecode == 4'b0000);
  assign link_up   = (state == ST_ACTIVE);
  assign phy_tvalid = link_up & (|req_tvalid);
  assign handshake = phy_tvalid & phy_tready;
  assign sel       = lock ? lock_idx : rr_sel;
  assign next_ptr  = (sel == LAST_IDX) ? '0 : sel + 1'b1;

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PHY_RST;
      timer       <= '0;
      phy_arstn   <= 1'b0;
      retrain_cnt <= '0;
    end else begin
      timer <= timer - 32'd1;
      case (state)
        ST_PHY_RST: begin
          if (elapsed == TC_RST) begin
            state     <= ST_WAIT_LINK;
            timer     <= '0;
            phy_arstn <= 1'b1;
          end
        end
        ST_WAIT_LINK: begin
          if (link_ok) begin
            state <= ST_ACTIVE;
            timer <= '0;
          end else if (elapsed == TC_LINK) begin
            state     <= ST_PHY_RST;
            timer     <= '0;
            phy_arstn <= 1'b0;
            if (retrain_cnt != 8'hFF) retrain_cnt <= retrain_cnt + 8'd1;
          end
        end
        ST_ACTIVE: begin
          timer <= '0;
          if (!link_ok) begin
            state <= ST_ERR_HOLD;
            if (retrain_cnt != 8'hFF) retrain_cnt <= retrain_cnt + 8'd1;
          end
        end
        ST_ERR_HOLD: begin
          if (elapsed == TC_RETRY) begin
            state     <= ST_PHY_RST;
            timer     <= '0;
            phy_arstn <= 1'b0;
          end
        end
        default: begin
          state     <= ST_PHY_RST;
          timer     <= '0;
          phy_arstn <= 1'b0;
        end
      endcase
    end
  end

  // Lock freezes the selection while a beat is stalled so tdata stays stable.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (handshake) rr_ptr <= next_ptr;
      if (!link_up || !link_ok || handshake) begin
        lock <= 1'b0;
      end else if (phy_tvalid) begin
        lock     <= 1'b1;
        lock_idx <= sel;
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    int               j;
    rr_sel = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    j      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = IDX_W'(j);
      if (!found && req_tvalid[idx]) begin
        rr_sel = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    phy_tdata  = '0;
    req_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        phy_tdata     = req_tdata[i*DATA_W +: DATA_W];
        req_tready[i] = link_up & phy_tready;
      end
    end
  end

`ifdef QECIPHY_ARB_STATS_EN
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
    end else if (handshake) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sel == IDX_W'(i)) stat_beats[i*32 +: 32] <= stat_beats[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qeciphy_tx_link_arbiter.sv
// Directed bench for qeciphy_tx_link_arbiter: bring-up, round-robin, lock, retrain, timeout, async reset.
// Uses a shortened link timeout so saturation of retrain_cnt is reachable.
module tb_qeciphy_tx_link_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 64;
  localparam int RST_CYCLES   = 16;
  localparam int LINK_TIMEOUT = 64;
  localparam int RETRY_WAIT   = 1024;

  logic                      ACLK = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ*DATA_W-1:0] req_tdata;
  logic [NUM_REQ-1:0]        req_tvalid;
  logic [NUM_REQ-1:0]        req_tready;
  logic [DATA_W-1:0]         phy_tdata;
  logic                      phy_tvalid;
  logic                      phy_tready;
  logic [3:0]                phy_status;
  logic [3:0]                phy_ecode;
  logic                      phy_arstn;
  logic                      link_up;
  logic [7:0]                retrain_cnt;
`ifdef QECIPHY_ARB_STATS_EN
  logic [NUM_REQ*32-1:0]     stat_beats;
`endif

  logic [DATA_W-1:0] dat [NUM_REQ];
  int n_chk = 0;
  int n_err = 0;
  int hs_cnt = 0;

  always #5 ACLK = ~ACLK;
  assign req_tdata = {dat[3], dat[2], dat[1], dat[0]};

  always @(posedge ACLK) if (rst_n && phy_tvalid && phy_tready) hs_cnt++;

  qeciphy_tx_link_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES),
    .LINK_TIMEOUT(LINK_TIMEOUT), .RETRY_WAIT(RETRY_WAIT)
  ) dut (
    .ACLK(ACLK), .rst_n(rst_n),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .phy_tdata(phy_tdata), .phy_tvalid(phy_tvalid), .phy_tready(phy_tready),
    .phy_status(phy_status), .phy_ecode(phy_ecode), .phy_arstn(phy_arstn),
    .link_up(link_up), .retrain_cnt(retrain_cnt)
`ifdef QECIPHY_ARB_STATS_EN
    , .stat_beats(stat_beats)
`endif
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_arstn(input logic lvl, input int limit, output int n);
    n = 0;
    while (phy_arstn !== lvl && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int rise;
    int n;
    int hs0;
    rst_n      = 1'b0;
    req_tvalid = '0;
    phy_tready = 1'b0;
    phy_status = 4'h0;
    phy_ecode  = 4'h0;
    for (int i = 0; i < NUM_REQ; i++) dat[i] = 64'hD000 + 64'(i);

    repeat (3) tick();
    chk("rst_arstn", phy_arstn, 0);
    chk("rst_link", link_up, 0);
    chk("rst_tvalid", phy_tvalid, 0);
    chk("rst_tready", req_tready, 0);
    chk("rst_retrain", retrain_cnt, 0);

    // Bring-up: status good from cycle 30 after release.
    rst_n = 1'b1;
    rise  = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (phy_arstn && rise == 0) rise = c;
      if (c == 29) begin
        chk("pre_link", link_up, 0);
        phy_status = 4'b0100;
      end
    end
    chk("arstn_low_len", rise, 16);
    chk("link_up", link_up, 1);
    chk("bring_retrain", retrain_cnt, 0);

    // Round-robin with every requester valid.
    req_tvalid = 4'b1111;
    phy_tready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("rr_data", phy_tdata, 64'hD000 + 64'(k % 4));
      chk("rr_ready", req_tready, 64'(1 << (k % 4)));
      tick();
    end
`ifdef QECIPHY_ARB_STATS_EN
    chk("stat0", stat_beats[31:0], 3);
    chk("stat3", stat_beats[127:96], 3);
`endif
    req_tvalid = '0;
    #1;
    chk("idle_tvalid", phy_tvalid, 0);

    // Backpressure lock on requester 2; requester 0 appears while stalled.
    dat[2]     = 64'hA5;
    req_tvalid = 4'b0100;
    phy_tready = 1'b0;
    #1;
    chk("bp_data0", phy_tdata, 64'hA5);
    chk("bp_valid", phy_tvalid, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req_tvalid = 4'b0101;
      #1;
      chk("bp_lock_data", phy_tdata, 64'hA5);
      chk("bp_lock_rdy", req_tready, 0);
    end
    phy_tready = 1'b1;
    #1;
    chk("bp_grant2", req_tready, 4'b0100);
    tick();
    req_tvalid = 4'b0001;
    #1;
    chk("bp_next_data", phy_tdata, dat[0]);
    chk("bp_next_rdy", req_tready, 4'b0001);
    tick();
    req_tvalid = '0;

    // Link error with a stalled beat pending on requester 1.
    dat[1]     = 64'hBEEF;
    req_tvalid = 4'b0010;
    phy_tready = 1'b0;
    hs0 = hs_cnt;
    #1;
    chk("err_pend", phy_tvalid, 1);
    tick();
    phy_ecode = 4'h3;
    tick();
    phy_ecode = 4'h0;
    chk("err_tvalid", phy_tvalid, 0);
    chk("err_retrain", retrain_cnt, 1);
    chk("err_link", link_up, 0);
    chk("err_arstn", phy_arstn, 1);
    wait_arstn(1'b0, 2000, n);
    chk("err_hold_len", n, 1024);
    wait_arstn(1'b1, 100, n);
    chk("err_rst_len", n, 16);
    tick();
    chk("relink", link_up, 1);
    phy_tready = 1'b1;
    #1;
    chk("replay_data", phy_tdata, 64'hBEEF);
    chk("replay_rdy", req_tready, 4'b0010);
    tick();
    req_tvalid = '0;
    phy_tready = 1'b0;
    #1;
    chk("replay_once", hs_cnt - hs0, 1);

    // Link drop followed by repeated link-up timeouts.
    phy_status = 4'h0;
    tick();
    chk("drop_retrain", retrain_cnt, 2);
    wait_arstn(1'b0, 2000, n);
    chk("drop_hold_len", n, 1024);
    for (int p = 0; p < 2; p++) begin
      wait_arstn(1'b1, 100, n);
      chk("to_rst_len", n, 16);
      wait_arstn(1'b0, 200, n);
      chk("to_wait_len", n, 64);
      chk("to_retrain", retrain_cnt, 64'(3 + p));
    end
    n = 0;
    while (retrain_cnt != 8'hFF && n < 30000) begin
      tick();
      n++;
    end
    chk("sat_reach", retrain_cnt, 8'hFF);
    repeat (200) tick();
    chk("sat_hold", retrain_cnt, 8'hFF);

    // Async reset in the middle of traffic.
    phy_status = 4'b0100;
    n = 0;
    while (!link_up && n < 300) begin
      tick();
      n++;
    end
    chk("relink2", link_up, 1);
    req_tvalid = 4'b1111;
    phy_tready = 1'b1;
    repeat (3) tick();
    chk("ptr_pre", dut.rr_ptr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", phy_tvalid, 0);
    chk("arst_arstn", phy_arstn, 0);
    chk("arst_ptr", dut.rr_ptr, 0);
    chk("arst_retrain", retrain_cnt, 0);
    chk("arst_tready", req_tready, 0);
    tick();
    rst_n = 1'b1;
    req_tvalid = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
